// File: rtl/frv_alu_div_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frv_alu_div_serial_pkg
//  Description : Shared ALU definitions: default operand width and the
//                iterative-unit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package frv_alu_div_serial_pkg;

    // Operand width shared with the serial multiplier
    localparam int FRV_ALU_LEN = 32;

    // Iterative unit FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } frv_alu_state_t;

endpackage : frv_alu_div_serial_pkg
`default_nettype wire

// File: rtl/frv_alu_div_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : frv_alu_div_serial_if
//  Description : Request/result bundle between the ALU (master) and the
//                serial divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface frv_alu_div_serial_if
    import frv_alu_div_serial_pkg::*;
#(
    parameter int LEN = FRV_ALU_LEN
);
    logic [LEN-1:0] lhs;
    logic [LEN-1:0] rhs;
    logic           op_signed;
    logic           valid;
    logic           done;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;

    modport master (
        output lhs, rhs, op_signed, valid,
        input  done, quotient, remainder
    );

    modport slave (
        input  lhs, rhs, op_signed, valid,
        output done, quotient, remainder
    );
endinterface : frv_alu_div_serial_if
`default_nettype wire

// File: rtl/frv_alu_div_serial_cneg.sv
`default_nettype none
// ============================================================================
//  Module      : frv_alu_cneg
//  Description : Conditional two's-complement negate (en ? -din : din),
//                modulo 2^W. Shared by the serial divider and multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_alu_cneg #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] din,
    input  wire logic         en,
    output logic      [W-1:0] dout
);

    assign dout = en ? (-din) : din;

endmodule : frv_alu_cneg
`default_nettype wire

// File: rtl/frv_alu_div_serial.sv
`default_nettype none
// ============================================================================
//  Module      : frv_alu_div_serial
//  Description : Iterative signed/unsigned restoring divider, one quotient
//                bit per cycle on operand magnitudes, followed by a sign
//                fix-up cycle. Quotient and remainder are produced together.
//                Optional macro FRV_DIV_ZERO_EARLY_EN: a zero divisor jumps
//                straight from IDLE to DONE (latency 1) with the same
//                results as the full sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_alu_div_serial
    import frv_alu_div_serial_pkg::*;
#(
    parameter int LEN = FRV_ALU_LEN
) (
    input  wire logic               clk,
    input  wire logic               reset,
    frv_alu_div_serial_if.slave     bus
);

    localparam int CL = $clog2(LEN);

    frv_alu_state_t state;
    frv_alu_state_t state_next;

    logic [LEN-1:0] dvd;        // dividend magnitude, becomes the quotient
    logic [LEN-1:0] dsr;        // divisor magnitude
    logic [LEN-1:0] rem;        // partial remainder
    logic [CL-1:0]  count;
    logic           neg_q;
    logic           neg_r;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;

    logic           lhs_neg;
    logic           rhs_neg;
    logic           rhs_zero;
    logic [LEN-1:0] lhs_mag;
    logic [LEN-1:0] rhs_mag;
    logic [LEN-1:0] q_fix;
    logic [LEN-1:0] r_fix;
    logic [LEN:0]   shifted;
    logic [LEN:0]   trial;
    logic           borrow;
    logic [LEN-1:0] rem_next;
    logic           last_step;

    assign lhs_neg  = bus.op_signed & bus.lhs[LEN-1];
    assign rhs_neg  = bus.op_signed & bus.rhs[LEN-1];
    assign rhs_zero = (bus.rhs == '0);

    // Magnitudes of the operands; 2^(LEN-1) is representable as unsigned
    frv_alu_cneg #(.W(LEN)) u_cneg_lhs (.din(bus.lhs), .en(lhs_neg), .dout(lhs_mag));
    frv_alu_cneg #(.W(LEN)) u_cneg_rhs (.din(bus.rhs), .en(rhs_neg), .dout(rhs_mag));

    // Signed results from the unsigned quotient/remainder
    frv_alu_cneg #(.W(LEN)) u_cneg_q (.din(dvd), .en(neg_q), .dout(q_fix));
    frv_alu_cneg #(.W(LEN)) u_cneg_r (.din(rem), .en(neg_r), .dout(r_fix));

    // One restoring step: borrow out of the LEN+1 bit subtract means the
    // divisor did not fit, so keep the shifted remainder (its MSB is then 0)
    assign shifted   = {rem, dvd[LEN-1]};
    assign trial     = shifted - {1'b0, dsr};
    assign borrow    = trial[LEN];
    assign rem_next  = borrow ? shifted[LEN-1:0] : trial[LEN-1:0];
    assign last_step = (count == CL'(LEN - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping valid while busy abandons the operation
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.valid) begin
`ifdef FRV_DIV_ZERO_EARLY_EN
                    state_next = rhs_zero ? ST_DONE : ST_CALC;
`else
                    state_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (!bus.valid) begin
                    state_next = ST_IDLE;
                end else if (last_step) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = bus.valid ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift/subtract iterations, result fix-up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        dvd   <= lhs_mag;
                        dsr   <= rhs_mag;
                        rem   <= '0;
                        count <= '0;
                        // A zero divisor must yield an all-ones quotient
                        neg_q <= bus.op_signed & (bus.lhs[LEN-1] ^ bus.rhs[LEN-1]) & ~rhs_zero;
                        neg_r <= lhs_neg;
`ifdef FRV_DIV_ZERO_EARLY_EN
                        if (rhs_zero) begin
                            quotient  <= '1;
                            remainder <= bus.lhs;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    if (bus.valid) begin
                        rem   <= rem_next;
                        dvd   <= {dvd[LEN-2:0], ~borrow};
                        count <= count + CL'(1);
                    end
                end
                ST_FIX: begin
                    if (bus.valid) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done      = (state == ST_DONE);
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;

endmodule : frv_alu_div_serial
`default_nettype wire

// File: tb/tb_frv_alu_div_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frv_alu_div_serial
//  Description : Directed self-checking bench for frv_alu_div_serial, LEN=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_alu_div_serial;
    import frv_alu_div_serial_pkg::*;

    localparam int LEN = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    frv_alu_div_serial_if #(.LEN(LEN)) bus ();

    frv_alu_div_serial #(.LEN(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a request (caller is 1ns after an edge, DUT idle or in DONE);
    // returns edges until done is seen, -1 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit keep, output int lat,
                         output logic [31:0] q, output logic [31:0] r);
        bus.lhs       = a;
        bus.rhs       = b;
        bus.op_signed = s;
        bus.valid     = 1'b1;
        lat = -1;
        q   = 'x;
        r   = 'x;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                q   = bus.quotient;
                r   = bus.remainder;
                break;
            end
        end
        if (!keep) begin
            bus.valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.lhs   = '0;
        bus.rhs   = '0;
        bus.op_signed = 1'b0;
        #1;
        total++;
        if (bus.quotient !== 32'h0) begin bad++; $display("FAIL reset_q got=%h want=%h", bus.quotient, 32'h0); end
        total++;
        if (bus.remainder !== 32'h0) begin bad++; $display("FAIL reset_r got=%h want=%h", bus.remainder, 32'h0); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat; logic [31:0] q, r;
        do_op(32'd100, 32'd7, 1'b0, 1'b0, lat, q, r);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL udiv_latency got=%0d want=34", lat); end
        total++;
        if (q !== 32'd14) begin bad++; $display("FAIL udiv_q got=%h want=%h", q, 32'd14); end
        total++;
        if (r !== 32'd2) begin bad++; $display("FAIL udiv_r got=%h want=%h", r, 32'd2); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] q, r;
        do_op(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, lat, q, r);
        total++;
        if (q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE)
            begin bad++; $display("FAIL sdiv_neg_lhs got=%h/%h want=fffffff2/fffffffe", q, r); end
        do_op(32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, lat, q, r);
        total++;
        if (q !== 32'hFFFFFFF2 || r !== 32'd2)
            begin bad++; $display("FAIL sdiv_neg_rhs got=%h/%h want=fffffff2/00000002", q, r); end
        do_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b0, lat, q, r);
        total++;
        if (q !== 32'd14 || r !== 32'hFFFFFFFE)
            begin bad++; $display("FAIL sdiv_neg_both got=%h/%h want=0000000e/fffffffe", q, r); end
        total++;
        if (lat !== 34) begin bad++; $display("FAIL sdiv_latency got=%0d want=34", lat); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] q, r;
        int exp_lat;
`ifdef FRV_DIV_ZERO_EARLY_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        do_op(32'h80000005, 32'h0, 1'b1, 1'b0, lat, q, r);
        total++;
        if (q !== 32'hFFFFFFFF || r !== 32'h80000005)
            begin bad++; $display("FAIL divz_signed got=%h/%h want=ffffffff/80000005", q, r); end
        total++;
        if (lat !== exp_lat) begin bad++; $display("FAIL divz_latency got=%0d want=%0d", lat, exp_lat); end
        do_op(32'h80000005, 32'h0, 1'b0, 1'b0, lat, q, r);
        total++;
        if (q !== 32'hFFFFFFFF || r !== 32'h80000005)
            begin bad++; $display("FAIL divz_unsigned got=%h/%h want=ffffffff/80000005", q, r); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] q, r;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, lat, q, r);
        total++;
        if (q !== 32'h80000000 || r !== 32'h0)
            begin bad++; $display("FAIL ovf_signed got=%h/%h want=80000000/00000000", q, r); end
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, lat, q, r);
        total++;
        if (q !== 32'h0 || r !== 32'h80000000)
            begin bad++; $display("FAIL ovf_unsigned got=%h/%h want=00000000/80000000", q, r); end
    endtask

    task automatic test_abort();
        bit seen_done;
        // Outputs currently hold 0 / 0x80000000 from the unsigned overflow case
        bus.lhs = 32'h12345678; bus.rhs = 32'h11; bus.op_signed = 1'b0; bus.valid = 1'b1;
        @(posedge clk); #1;                       // IDLE -> CALC
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        bus.valid = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
        total++;
        if (dut.state !== ST_IDLE) begin bad++; $display("FAIL abort_idle got=%0d want=%0d", dut.state, ST_IDLE); end
        total++;
        if (bus.quotient !== 32'h0 || bus.remainder !== 32'h80000000)
            begin bad++; $display("FAIL abort_hold got=%h/%h want=00000000/80000000", bus.quotient, bus.remainder); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] q, r;
        do_op(32'd1000, 32'd3, 1'b0, 1'b0, lat, q, r);   // outputs nonzero: 333 / 1
        bus.lhs = 32'hDEADBEEF; bus.rhs = 32'h5; bus.op_signed = 1'b0; bus.valid = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        total++;
        if (bus.quotient !== 32'h0 || bus.remainder !== 32'h0 || bus.done !== 1'b0)
            begin bad++; $display("FAIL reset_mid got=%h/%h/%b want=0/0/0", bus.quotient, bus.remainder, bus.done); end
        bus.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, lat, q, r);
        total++;
        if (q !== 32'h0FFFFFFF || r !== 32'hF || lat !== 34)
            begin bad++; $display("FAIL after_reset got=%h/%h lat=%0d want=0fffffff/0000000f lat=34", q, r, lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] q, r;
        do_op(32'd50, 32'd8, 1'b0, 1'b1, lat, q, r);
        total++;
        if (q !== 32'd6 || r !== 32'd2) begin bad++; $display("FAIL b2b_first got=%h/%h want=00000006/00000002", q, r); end
        do_op(32'd9, 32'd3, 1'b0, 1'b0, lat, q, r);
        total++;
        if (lat !== 35) begin bad++; $display("FAIL b2b_latency got=%0d want=35", lat); end
        total++;
        if (q !== 32'd3 || r !== 32'd0) begin bad++; $display("FAIL b2b_second got=%h/%h want=00000003/00000000", q, r); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_frv_alu_div_serial
`default_nettype wire

// File: doc/frv_alu_div_serial.md
Name: frv_alu_div_serial

Overview:
- Iterative signed/unsigned integer divider; the inverse-direction companion to the core's serial multiplier in the ALU.
- Produces quotient and remainder together, one quotient bit per cycle, using restoring division on operand magnitudes with final sign correction.
- Issued by the ALU for RISC-V DIV/DIVU/REM/REMU. The ALU holds `valid` until `done`, using the same handshake as the multiplier.

Parameters:
- LEN, 32, operand width in bits (>=4). CL = $clog2(LEN) is derived locally.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- lhs  in  LEN  dividend.
- rhs  in  LEN  divisor.
- op_signed  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- valid  in  1  request; held high with stable operands until `done`.
- done  out  1  one-cycle pulse; `quotient` and `remainder` are valid in this cycle.
- quotient  out  LEN  registered result.
- remainder  out  LEN  registered result.

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - FSM goes to IDLE; count, accumulators, quotient and remainder all clear to 0; done = 0.
  - Reset mid-operation abandons the operation with no done.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: when valid=1, latch |lhs| and |rhs| (magnitude only if op_signed and MSB set). Latch neg_q = op_signed & (lhs[LEN-1]^rhs[LEN-1]) & (rhs!=0) and neg_r = op_signed & lhs[LEN-1]. Clear the partial remainder and count. Go to CALC.
  - CALC: each cycle, trial = {rem[LEN-1:0], dvd[LEN-1]} - {1'b0, dsr}, computed LEN+1 wide. If there is no borrow, rem = trial and the quotient bit is 1; otherwise rem = the shifted value and the bit is 0. The quotient bit shifts into dvd's LSB. After LEN cycles (count == LEN-1), go to FIX.
  - FIX: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r. Go to DONE.
  - DONE: done=1 for this cycle only. Next state is IDLE.
- Latency: done asserts exactly LEN+2 cycles after the first cycle valid is seen high in IDLE.
- Back-to-back: if valid is still high in the cycle after done, a new operation starts with the current operands.
- Abort: valid=0 in CALC or FIX returns to IDLE next cycle. done is not asserted and the outputs keep their previous values.
- Outputs: quotient and remainder hold their values from DONE until the next FIX. done is combinationally (state==DONE), with no dependency on valid.
- Divide by zero, no special path:
  - Quotient is all ones (neg_q is forced to 0).
  - Remainder equals lhs, for both signed and unsigned.
- Signed overflow (lhs = 2^(LEN-1), rhs = -1, op_signed): quotient = lhs, remainder = 0. This falls out of the magnitude algorithm and must not be special-cased in a way that changes the result.
- Width rules:
  - Magnitudes are LEN-bit unsigned; the magnitude of the most-negative value is 2^(LEN-1), which is representable.
  - The subtractor is LEN+1 bits and the borrow is its MSB.
  - Negation is two's complement modulo 2^LEN.
- Operands are sampled only in IDLE. Changes on lhs/rhs/op_signed while busy are ignored.

Optional Feature:
- Macro: FRV_DIV_ZERO_EARLY_EN.
- Defined: in IDLE with rhs==0, go directly to DONE.
  - quotient = all ones, remainder = lhs.
  - done asserts 1 cycle after the request (latency 1). CALC and FIX are skipped.
- Undefined: divide by zero runs the full LEN+2 cycle sequence with identical results.

Decomposition:
- Shared ALU header/package:
  - FSM state encodings (2-bit: IDLE=0, CALC=1, FIX=2, DONE=3).
  - The default LEN value shared with the multiplier.
- No sub-module is required.
- A small combinational conditional-negate helper (frv_alu_cneg: in, en -> en ? -in : in) is natural. It is used twice for operand magnitudes and twice in FIX, and the multiplier may reuse it.

Test Plan:
- Unsigned, LEN=32: lhs=100, rhs=7, op_signed=0 -> done at cycle 34; quotient=14, remainder=2.
- Signed: lhs=-100 (0xFFFFFF9C), rhs=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). lhs=100, rhs=-7 -> quotient=-14, remainder=2.
- Divide by zero:
  - lhs=0x80000005, rhs=0, signed -> quotient=0xFFFFFFFF, remainder=0x80000005.
  - Same operands unsigned -> same result.
  - Repeat with FRV_DIV_ZERO_EARLY_EN defined -> done 1 cycle after the request.
- Overflow: lhs=0x80000000, rhs=0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x80000000.
- Abort/reset:
  - Drop valid at cycle 10 of CALC -> no done; FSM returns to IDLE; outputs unchanged.
  - Assert reset mid-CALC -> outputs go to 0 immediately.
  - A new request afterward gives the correct result (e.g. 0xFFFFFFFF/0x10, unsigned -> 0x0FFFFFFF, remainder 0xF).
- Back-to-back: hold valid high across done with operands switched to 9/3 -> second done exactly LEN+3 cycles after the first, with quotient=3, remainder=0.
